// File: rtl/image_line_feeder.sv
// rtl/image_line_feeder.sv - streams a grayscale image line by line from byte RAM into the filter's stream input
//
// Ports:
//   axis_clk        single clock, rising edge
//   axis_reset      asynchronous active-high reset
//   i_start         one-cycle start pulse, honoured only when idle
//   o_busy          high while a frame is in progress (until o_done)
//   o_done          one-cycle pulse after the final pad pixel handshake
//   o_mem_rd_en     RAM read strobe
//   o_mem_addr      RAM address (line*IMAGE_WIDTH + column)
//   i_mem_data      RAM read data, valid one cycle after o_mem_rd_en
//   i_intr          filter interrupt; each rising edge grants one line credit
//   o_m_data_valid  stream valid
//   o_m_data        stream pixel
//   i_m_ready       stream ready

module image_line_feeder #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PRIME_LINES  = 4,
  parameter int PAD_LINES    = 2,
  parameter int ADDR_W       = 18
) (
  input  logic              axis_clk,
  input  logic              axis_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  input  logic              i_intr,
  output logic              o_m_data_valid,
  output logic [7:0]        o_m_data,
  input  logic              i_m_ready
);

  localparam int COL_W       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int TOTAL_LINES = IMAGE_HEIGHT + PAD_LINES;
  localparam int LINE_W      = $clog2(TOTAL_LINES + 1);

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [LINE_W-1:0] LAST_PRIME = LINE_W'(PRIME_LINES - 1);
  localparam logic [LINE_W-1:0] IMG_LINES  = LINE_W'(IMAGE_HEIGHT);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(TOTAL_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_WAIT, S_SEND, S_PAD, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          credit_q, credit_d;
  logic                intr_q;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                inflight_q;
  logic [1:0]          cnt_q, cnt_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [7:0]          mem_q [2];

  logic       intr_rise;
  logic       credit_dec;
  logic       img_issue;
  logic       pad_issue;
  logic       pop_free;
  logic [2:0] slots_used;
  logic       can_issue;
  logic       last_col;
  logic       push;
  logic [7:0] push_data;
  logic       fifo_empty;
  logic       pop;
  logic       fifo_write;
  logic       fifo_adv;

  assign intr_rise = i_intr & ~intr_q;

  // A pop frees a slot only when it consumes stored or in-flight data; a pad
  // pixel bypassing an empty FIFO never occupied a slot. Keeping the pad
  // bypass out of this term also keeps issue logic independent of valid.
  assign pop_free   = i_m_ready & ((cnt_q != 2'd0) | inflight_q);
  assign slots_used = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_free};
  assign can_issue  = (slots_used < 3'd2);
  assign last_col   = (col_q == LAST_COL);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    addr_d     = addr_q;
    img_issue  = 1'b0;
    pad_issue  = 1'b0;
    credit_dec = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_PRIME;
          col_d   = '0;
          line_d  = '0;
          addr_d  = '0;
        end
      end

      S_PRIME, S_SEND: begin
        if (can_issue) begin
          img_issue = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
          if (last_col) begin
            col_d  = '0;
            line_d = line_q + LINE_W'(1);
            // Pad lines are still owed after priming, so WAIT is always next.
            if (state_q == S_SEND || line_q == LAST_PRIME) begin
              state_d = S_WAIT;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      S_WAIT: begin
        if (credit_q != 2'd0) begin
          credit_dec = 1'b1;
          state_d    = (line_q < IMG_LINES) ? S_SEND : S_PAD;
        end
      end

      S_PAD: begin
        if (can_issue) begin
          pad_issue = 1'b1;
          if (last_col) begin
            col_d  = '0;
            line_d = line_q + LINE_W'(1);
            if (line_q == LAST_LINE) begin
              // An empty FIFO with ready high means this pixel is handed over now.
              state_d = ((cnt_q == 2'd0) && i_m_ready) ? S_DONE : S_DRAIN;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if ((cnt_q == 2'd0) || (cnt_q == 2'd1 && i_m_ready)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous edge and consume cancel out.
  always_comb begin
    credit_d = credit_q;
    if (intr_rise && !credit_dec) begin
      credit_d = (credit_q == 2'd3) ? 2'd3 : credit_q + 2'd1;
    end else if (credit_dec && !intr_rise) begin
      credit_d = credit_q - 2'd1;
    end
  end

  // Output FIFO with bypass: a push into an empty FIFO is presented at once,
  // and only stored if it is not accepted in the same cycle.
  always_comb begin
    push           = inflight_q | pad_issue;
    push_data      = inflight_q ? i_mem_data : 8'h00;
    fifo_empty     = (cnt_q == 2'd0);
    o_m_data_valid = ~fifo_empty | push;
    if (!fifo_empty) begin
      o_m_data = mem_q[rd_ptr_q];
    end else if (push) begin
      o_m_data = push_data;
    end else begin
      o_m_data = 8'h00;
    end
    pop        = o_m_data_valid & i_m_ready;
    fifo_write = push & ~(fifo_empty & pop);
    fifo_adv   = pop & ~fifo_empty;
    cnt_d      = cnt_q + {1'b0, fifo_write} - {1'b0, fifo_adv};
    wr_ptr_d   = fifo_write ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = fifo_adv ? ~rd_ptr_q : rd_ptr_q;
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q    <= S_IDLE;
      credit_q   <= 2'd0;
      intr_q     <= 1'b0;
      col_q      <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      mem_q[0]   <= 8'h00;
      mem_q[1]   <= 8'h00;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      intr_q     <= i_intr;
      col_q      <= col_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      inflight_q <= img_issue;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (fifo_write) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

  assign o_mem_rd_en = img_issue;
  assign o_mem_addr  = addr_q;
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_image_line_feeder.sv
// tb/tb_image_line_feeder.sv - self-checking bench for image_line_feeder

module tb_image_line_feeder;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PL = 4;
  localparam int PD = 2;
  localparam int AW = 18;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          intr  = 1'b0;
  logic          ready = 1'b1;
  logic          busy, done, rd_en, valid;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic [7:0]    mem_data = 8'h00;

  always #5 clk = ~clk;

  image_line_feeder #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PRIME_LINES (PL),
    .PAD_LINES   (PD),
    .ADDR_W      (AW)
  ) dut (
    .axis_clk      (clk),
    .axis_reset    (rst),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_mem_rd_en   (rd_en),
    .o_mem_addr    (addr),
    .i_mem_data    (mem_data),
    .i_intr        (intr),
    .o_m_data_valid(valid),
    .o_m_data      (data),
    .i_m_ready     (ready)
  );

  // RAM model: returns addr[7:0] one cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en) mem_data <= addr[7:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and event monitor
  int         exp_q[$];
  int         m_checks = 0, m_pass = 0;
  int         pop_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, stall_cnt = 0;
  int         pop_cyc[256];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        m_checks++;
        stall_cnt++;
        if (valid === 1'b1 && data === prev_data) m_pass++;
        else $display("FAIL stall_hold: valid=%0b data=%0d required valid=1 data=%0d", valid, data, prev_data);
      end
      if (valid && ready) begin
        m_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pixel: got data=%0d required no transfer", data);
        end else begin
          mon_e = exp_q.pop_front();
          if (data === mon_e[7:0]) m_pass++;
          else $display("FAIL pixel: got %0d required %0d", data, mon_e);
        end
        pop_cyc[pop_cnt % 256] = cyc;
        pop_cnt++;
      end
      prev_stall = valid & ~ready;
      prev_data  = data;
      if (rd_en) rd_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        m_checks++;
        if (busy === 1'b0) m_pass++;
        else $display("FAIL busy_at_done: got %0b required 0", busy);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  int t_checks = 0, t_pass = 0;
  int rd_base  = 0;

  task automatic check(input bit ok, input string nm, input int act, input int req);
    t_checks++;
    if (ok) t_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, req);
  endtask

  typedef struct {
    bit use_start;
    int n_pix;
    int first;
    bit zero;
    int lat;
    bit exp_done;
    int exp_reads;
  } phase_t;

  phase_t ph[5];

  task automatic run_phase(input phase_t p);
    int pbase, dbase, budget, lastc, firstv;
    pbase  = pop_cnt;
    dbase  = done_cnt;
    firstv = p.zero ? 0 : (p.first & 255);
    for (int i = 0; i < p.n_pix; i++) exp_q.push_back(p.zero ? 0 : ((p.first + i) & 255));
    @(posedge clk); #1;
    if (p.use_start) start = 1'b1; else intr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    intr  = 1'b0;
    repeat (p.lat - 2) @(posedge clk);
    #2;
    if (p.use_start) begin
      check(busy === 1'b1, "busy_after_start", int'(busy), 1);
      check(rd_en === 1'b1, "first_rd_en", int'(rd_en), 1);
      check(addr === '0, "first_addr", int'(addr), 0);
    end
    check(valid === 1'b0, "valid_before_latency", int'(valid), 0);
    @(posedge clk); #2;
    check(valid === 1'b1, "valid_at_latency", int'(valid), 1);
    check(data === firstv[7:0], "first_data", int'(data), firstv);
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (12) @(posedge clk);
    #2;
    lastc = pop_cyc[(pbase + p.n_pix - 1) % 256];
    check(pop_cnt - pbase == p.n_pix, "pixel_count", pop_cnt - pbase, p.n_pix);
    check(lastc - pop_cyc[pbase % 256] == p.n_pix - 1, "contiguous", lastc - pop_cyc[pbase % 256], p.n_pix - 1);
    check(rd_cnt - rd_base == p.exp_reads, "read_count", rd_cnt - rd_base, p.exp_reads);
    check(busy === !p.exp_done, "busy_after_phase", int'(busy), int'(!p.exp_done));
    check(done_cnt - dbase == int'(p.exp_done), "done_pulses", done_cnt - dbase, int'(p.exp_done));
    if (p.exp_done) check(done_cyc - lastc == 1, "done_timing", done_cyc - lastc, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_base = rd_cnt;
  endtask

  logic [3:0] pat = 4'b1001;

  initial begin
    int pbase, sbase, budget;

    ph[0] = '{1'b1, 32,  0, 1'b0, 2, 1'b0, 32};
    ph[1] = '{1'b0,  8, 32, 1'b0, 3, 1'b0, 40};
    ph[2] = '{1'b0,  8, 40, 1'b0, 3, 1'b0, 48};
    ph[3] = '{1'b0,  8,  0, 1'b1, 2, 1'b0, 48};
    ph[4] = '{1'b0,  8,  0, 1'b1, 2, 1'b1, 48};

    // reset state
    repeat (2) @(posedge clk);
    #2;
    check(busy === 1'b0, "rst_busy", int'(busy), 0);
    check(done === 1'b0, "rst_done", int'(done), 0);
    check(rd_en === 1'b0, "rst_rd_en", int'(rd_en), 0);
    check(addr === '0, "rst_addr", int'(addr), 0);
    check(valid === 1'b0, "rst_valid", int'(valid), 0);
    check(data === 8'h00, "rst_data", int'(data), 0);
    @(posedge clk); #1 rst = 1'b0;
    rd_base = rd_cnt;

    // full frame with ready held high, one interrupt per gated line
    for (int i = 0; i < 5; i++) run_phase(ph[i]);

    // backpressure during priming, two early credits carry lines 4 and 5
    do_reset();
    pbase = pop_cnt;
    sbase = stall_cnt;
    for (int i = 0; i < 48; i++) exp_q.push_back(i);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      begin
        for (int k = 0; k < 240; k++) begin
          ready = pat[k % 4];
          @(posedge clk); #1;
        end
        ready = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        #1 intr = 1'b1;
        @(posedge clk); #1 intr = 1'b0;
        repeat (2) @(posedge clk);
        #1 intr = 1'b1;
        @(posedge clk); #1 intr = 1'b0;
      end
    join
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    check(exp_q.size() == 0, "stall_drain", exp_q.size(), 0);
    repeat (10) @(posedge clk);
    #2;
    check(pop_cnt - pbase == 48, "stall_pixel_count", pop_cnt - pbase, 48);
    check(rd_cnt - rd_base == 48, "stall_read_count", rd_cnt - rd_base, 48);
    check(stall_cnt - sbase > 0, "stalls_observed", stall_cnt - sbase, 1);
    check(busy === 1'b1, "waiting_for_pad_credit", int'(busy), 1);
    run_phase(ph[3]);
    run_phase(ph[4]);

    // asynchronous reset in the middle of line 2, then a clean restart
    do_reset();
    pbase = pop_cnt;
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 intr = 1'b1;
    @(posedge clk); #1 intr = 1'b0;
    budget = 0;
    while (pop_cnt - pbase < 20 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    check(pop_cnt - pbase >= 20, "reach_line2", pop_cnt - pbase, 20);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check(busy === 1'b0, "async_rst_busy", int'(busy), 0);
    check(done === 1'b0, "async_rst_done", int'(done), 0);
    check(rd_en === 1'b0, "async_rst_rd_en", int'(rd_en), 0);
    check(addr === '0, "async_rst_addr", int'(addr), 0);
    check(valid === 1'b0, "async_rst_valid", int'(valid), 0);
    check(data === 8'h00, "async_rst_data", int'(data), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_base = rd_cnt;
    run_phase(ph[0]);

    $display("%0d/%0d checks passed", t_pass + m_pass, t_checks + m_checks);
    $finish;
  end

endmodule
